associative_memory_multiclass: RTL and testbench
================================================

# associative_memory_multiclass

Parametrised associative memory for the HD sensor-fusion classifier: majority-bundles three modality hypervectors into a query, then finds the nearest stored class by Hamming distance in CHANNELS independent class memories (e.g. arousal, valence, ...). Class hypervectors are loaded at run time through a write port instead of being compiled-in constants. Sits after the spatial/temporal encoders and drives the label/distance outputs of the fusion pipeline.

## Interface
- HV_DIMENSION, 2000: hypervector width in bits.
- CLASSES, 2: classes per channel, minimum 2.
- CHANNELS, 2: independent class memories searched in parallel with the same query.
- LABEL_WIDTH, ceilLog2(CLASSES): width of one label (minimum 1).
- DISTANCE_WIDTH, ceilLog2(HV_DIMENSION+1): width of one distance.
- Clk_CI  in  1  clock; all state changes on the rising edge.
- Reset_RI  in  1  asynchronous, active-high reset.
- ValidIn_SI  in  1  query inputs valid.
- ReadyOut_SO  out  1  block accepts a query.
- HypervectorIn_mod1_DI / mod2 / mod3  in  HV_DIMENSION each  modality hypervectors, bit 0 is MSB ([0:HV_DIMENSION-1]).
- ValidOut_SO  out  1  results valid.
- ReadyIn_SI  in  1  downstream accepts results.
- LabelOut_DO  out  CHANNELS*LABEL_WIDTH  winning class per channel, channel 0 in LSBs.
- DistanceOut_DO  out  CHANNELS*DISTANCE_WIDTH  winning distance per channel, channel 0 in LSBs.
- AmWrEn_SI  in  1  class-memory write strobe.
- AmWrReady_SO  out  1  write accepted this cycle.
- AmWrChannel_DI  in  ceilLog2(CHANNELS) (minimum 1)  target channel.
- AmWrClass_DI  in  LABEL_WIDTH  target class.
- AmWrData_DI  in  HV_DIMENSION  class hypervector.
- MarginOut_DO  out  CHANNELS*DISTANCE_WIDTH  present only with AM_MARGIN_EN.

## Operation
- Query = bitwise majority of the three inputs, registered on acceptance.
- FSM states:
  - IDLE: ReadyOut_SO=1 and AmWrReady_SO=1. On ValidIn_SI, capture the query, clear the class counter, and go to SEARCH.
  - SEARCH: counter c runs 0..CLASSES-1, one class per cycle. Every channel computes popcount(query XOR AM[ch][c]) combinationally. The comparator register loads unconditionally at c=0. For c>0 it updates only on strictly smaller distance, so on a tie the lowest class index wins. At c=CLASSES-1 the final comparator result (including that cycle's compare) is written to the output buffers and the FSM goes to DONE.
  - DONE: ValidOut_SO=1 and outputs are held stable. On ReadyIn_SI, go to IDLE.
- AM writes are accepted only in IDLE (AmWrReady_SO=1). A write with AmWrEn_SI stores AmWrData_DI at [AmWrChannel_DI][AmWrClass_DI].
  - Out-of-range channel or class: the write is ignored.
  - A write and ValidIn_SI in the same IDLE cycle: both take effect, and the search uses the new contents.
  - Writes in SEARCH or DONE are dropped; AmWrReady_SO=0.
- Distance arithmetic is unsigned and saturation-free (the maximum is HV_DIMENSION).
- Reset (asynchronous, any state): FSM to IDLE; all AM entries, the query register, comparators and counter to 0; LabelOut_DO, DistanceOut_DO and MarginOut_DO to 0; ValidOut_SO=0. A search in progress is lost.

## Timing
- Query is accepted at edge k (ValidIn_SI & ReadyOut_SO).
- ValidOut_SO rises after edge k+CLASSES. Latency is CLASSES cycles, independent of CHANNELS.
- ReadyOut_SO=0 from edge k until the cycle after the DONE handshake. Throughput is one query per CLASSES+2 cycles with ReadyIn_SI held high.
- ValidOut_SO is held until ReadyIn_SI is sampled high, and the outputs do not change while it is held. The FSM returns to IDLE on that edge.
- All outputs are registered or decoded from the state register; no combinational input-to-output path.

## Configuration
- AM_MARGIN_EN defined:
  - Each channel also tracks the second-best distance, updated on strict less-than.
  - MarginOut_DO = second-best minus best, per channel, latched with the labels.
  - A tie between best and second-best gives margin 0.
  - Adds a port and one register per channel; latency is unchanged.
- Undefined: no second-best register and no MarginOut_DO port. All other behaviour is identical.

## Test plan
- Reset, then load CHANNELS=2, CLASSES=4 with AM[ch][c]=c-th one-hot-block pattern. Send a query equal to AM[0][2] with all three modalities identical -> label 2, distance 0 on channel 0; ValidOut_SO exactly 4 cycles after acceptance.
- Majority check: mod1=all-ones, mod2=all-ones, mod3=all-zeros with AM[ch][0]=all-ones -> label 0, distance 0 on both channels.
- Tie: AM[0][1] and AM[0][3] equidistant (distance 5) and best -> label 1, distance 5; with AM_MARGIN_EN, margin 0.
- Back-pressure: hold ReadyIn_SI=0 for 10 cycles in DONE -> outputs stable, ReadyOut_SO=0, AmWrEn_SI pulses dropped (later readback search unchanged).
- Async reset asserted mid-SEARCH (c=1) -> immediate ValidOut_SO=0, outputs 0, AM cleared; the next query against cleared AM -> label 0, distance = popcount(query).
- Simultaneous write to AM[1][0] and query acceptance in IDLE -> channel 1 result reflects the newly written vector.

Source files
------------

// File: rtl/associative_memory_multiclass_if.sv
// rtl/associative_memory_multiclass_if.sv - query/result/class-write bundle for associative_memory_multiclass
//
// Purpose: groups the query handshake, the result handshake and the
// class-memory write port of the associative memory into one interface.
// Optional feature macro: AM_MARGIN_EN (adds MarginOut_DO).
//
// Signals (slave = associative memory, master = surrounding pipeline):
//   ValidIn_SI / ReadyOut_SO          query handshake
//   HypervectorIn_mod1/2/3_DI         modality hypervectors, bit 0 is MSB
//   ValidOut_SO / ReadyIn_SI          result handshake
//   LabelOut_DO / DistanceOut_DO      per-channel winner, channel 0 in LSBs
//   AmWrEn_SI / AmWrReady_SO          class-memory write strobe / accept
//   AmWrChannel_DI / AmWrClass_DI     write target
//   AmWrData_DI                       class hypervector to store
//   MarginOut_DO                      second-best minus best (AM_MARGIN_EN)
interface associative_memory_multiclass_if #(
  parameter int HV_DIMENSION = 2000,
  parameter int CLASSES      = 2,
  parameter int CHANNELS     = 2
) ();
  localparam int LABEL_WIDTH    = (CLASSES > 2) ? $clog2(CLASSES) : 1;
  localparam int DISTANCE_WIDTH = $clog2(HV_DIMENSION + 1);
  localparam int CH_WIDTH       = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic                                  ValidIn_SI;
  logic                                  ReadyOut_SO;
  logic [0:HV_DIMENSION-1]               HypervectorIn_mod1_DI;
  logic [0:HV_DIMENSION-1]               HypervectorIn_mod2_DI;
  logic [0:HV_DIMENSION-1]               HypervectorIn_mod3_DI;
  logic                                  ValidOut_SO;
  logic                                  ReadyIn_SI;
  logic [CHANNELS*LABEL_WIDTH-1:0]       LabelOut_DO;
  logic [CHANNELS*DISTANCE_WIDTH-1:0]    DistanceOut_DO;
  logic                                  AmWrEn_SI;
  logic                                  AmWrReady_SO;
  logic [CH_WIDTH-1:0]                   AmWrChannel_DI;
  logic [LABEL_WIDTH-1:0]                AmWrClass_DI;
  logic [0:HV_DIMENSION-1]               AmWrData_DI;
`ifdef AM_MARGIN_EN
  logic [CHANNELS*DISTANCE_WIDTH-1:0]    MarginOut_DO;

  modport slave (
    input  ValidIn_SI, HypervectorIn_mod1_DI, HypervectorIn_mod2_DI, HypervectorIn_mod3_DI,
    input  ReadyIn_SI, AmWrEn_SI, AmWrChannel_DI, AmWrClass_DI, AmWrData_DI,
    output ReadyOut_SO, ValidOut_SO, LabelOut_DO, DistanceOut_DO, AmWrReady_SO, MarginOut_DO
  );

  modport master (
    output ValidIn_SI, HypervectorIn_mod1_DI, HypervectorIn_mod2_DI, HypervectorIn_mod3_DI,
    output ReadyIn_SI, AmWrEn_SI, AmWrChannel_DI, AmWrClass_DI, AmWrData_DI,
    input  ReadyOut_SO, ValidOut_SO, LabelOut_DO, DistanceOut_DO, AmWrReady_SO, MarginOut_DO
  );
`else
  modport slave (
    input  ValidIn_SI, HypervectorIn_mod1_DI, HypervectorIn_mod2_DI, HypervectorIn_mod3_DI,
    input  ReadyIn_SI, AmWrEn_SI, AmWrChannel_DI, AmWrClass_DI, AmWrData_DI,
    output ReadyOut_SO, ValidOut_SO, LabelOut_DO, DistanceOut_DO, AmWrReady_SO
  );

  modport master (
    output ValidIn_SI, HypervectorIn_mod1_DI, HypervectorIn_mod2_DI, HypervectorIn_mod3_DI,
    output ReadyIn_SI, AmWrEn_SI, AmWrChannel_DI, AmWrClass_DI, AmWrData_DI,
    input  ReadyOut_SO, ValidOut_SO, LabelOut_DO, DistanceOut_DO, AmWrReady_SO
  );
`endif
endinterface

// File: rtl/associative_memory_multiclass.sv
// rtl/associative_memory_multiclass.sv - multi-channel HD associative memory (majority bundle + Hamming search)
//
// Purpose: bundles three modality hypervectors by bitwise majority into a
// query, then searches CHANNELS run-time loadable class memories in parallel,
// one class per cycle, for the nearest class by Hamming distance. Ties go to
// the lowest class index.
// Optional feature macro: AM_MARGIN_EN (per-channel second-best tracking and
// MarginOut_DO = second-best minus best).
//
// Ports:
//   Clk_CI    clock, rising edge
//   Reset_RI  asynchronous active-high reset
//   am_if     associative_memory_multiclass_if.slave (query, result and
//             class-write handshakes; see the interface file)
module associative_memory_multiclass #(
  parameter int HV_DIMENSION = 2000,
  parameter int CLASSES      = 2,
  parameter int CHANNELS     = 2
) (
  input  logic                            Clk_CI,
  input  logic                            Reset_RI,
  associative_memory_multiclass_if.slave  am_if
);
  localparam int LABEL_WIDTH    = (CLASSES > 2) ? $clog2(CLASSES) : 1;
  localparam int DISTANCE_WIDTH = $clog2(HV_DIMENSION + 1);
  localparam int CH_WIDTH       = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  typedef logic [0:HV_DIMENSION-1]   hv_t;
  typedef logic [DISTANCE_WIDTH-1:0] dist_t;
  typedef logic [LABEL_WIDTH-1:0]    label_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam dist_t  DIST_MAX   = dist_t'(HV_DIMENSION);
  localparam label_t LAST_CLASS = label_t'(CLASSES - 1);

  // State
  state_t r_state;
  hv_t    r_query;
  hv_t    r_am [CHANNELS][CLASSES];
  label_t r_class_cnt;
  dist_t  r_best_dist [CHANNELS];
  label_t r_best_lbl  [CHANNELS];
  logic   r_ready_out;
  logic   r_valid_out;
  logic [CHANNELS*LABEL_WIDTH-1:0]    r_label_out;
  logic [CHANNELS*DISTANCE_WIDTH-1:0] r_dist_out;
`ifdef AM_MARGIN_EN
  dist_t  r_second_dist [CHANNELS];
  logic [CHANNELS*DISTANCE_WIDTH-1:0] r_margin_out;
`endif

  // Combinational search datapath
  hv_t    w_majority;
  hv_t    w_am_sel        [CHANNELS];
  dist_t  w_dist          [CHANNELS];
  dist_t  w_nxt_best_dist [CHANNELS];
  label_t w_nxt_best_lbl  [CHANNELS];
`ifdef AM_MARGIN_EN
  dist_t  w_nxt_second    [CHANNELS];
`endif
  logic   w_first;
  logic   w_last;
  logic   w_wr_fire;

  function automatic dist_t popcount(input hv_t v);
    dist_t s;
    s = '0;
    for (int i = 0; i < HV_DIMENSION; i++) begin
      s = s + dist_t'(v[i]);
    end
    return s;
  endfunction

  assign w_majority = (am_if.HypervectorIn_mod1_DI & am_if.HypervectorIn_mod2_DI) |
                      (am_if.HypervectorIn_mod1_DI & am_if.HypervectorIn_mod3_DI) |
                      (am_if.HypervectorIn_mod2_DI & am_if.HypervectorIn_mod3_DI);

  assign w_first   = (r_class_cnt == '0);
  assign w_last    = (r_class_cnt == LAST_CLASS);
  // Writes are only honoured while idle; ready is high exactly then.
  assign w_wr_fire = am_if.AmWrEn_SI & r_ready_out;

  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      // Mux by comparison so a non-power-of-two CLASSES never indexes past the array.
      w_am_sel[ch] = '0;
      for (int c = 0; c < CLASSES; c++) begin
        if (r_class_cnt == label_t'(c)) begin
          w_am_sel[ch] = r_am[ch][c];
        end
      end
      w_dist[ch] = popcount(r_query ^ w_am_sel[ch]);

      w_nxt_best_dist[ch] = r_best_dist[ch];
      w_nxt_best_lbl[ch]  = r_best_lbl[ch];
`ifdef AM_MARGIN_EN
      w_nxt_second[ch]    = r_second_dist[ch];
`endif
      if (w_first) begin
        // First class seeds the comparator; second-best starts at the worst possible distance.
        w_nxt_best_dist[ch] = w_dist[ch];
        w_nxt_best_lbl[ch]  = '0;
`ifdef AM_MARGIN_EN
        w_nxt_second[ch]    = DIST_MAX;
`endif
      end else if (w_dist[ch] < r_best_dist[ch]) begin
        // Strict less-than: on a tie the earlier (lower) class index keeps the win.
        w_nxt_best_dist[ch] = w_dist[ch];
        w_nxt_best_lbl[ch]  = r_class_cnt;
`ifdef AM_MARGIN_EN
        w_nxt_second[ch]    = r_best_dist[ch];
`endif
      end
`ifdef AM_MARGIN_EN
      else if (w_dist[ch] < r_second_dist[ch]) begin
        // A tie with the best lands here and produces margin 0.
        w_nxt_second[ch] = w_dist[ch];
      end
`endif
    end
  end

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      r_state     <= S_IDLE;
      r_query     <= '0;
      r_class_cnt <= '0;
      r_ready_out <= 1'b1;
      r_valid_out <= 1'b0;
      r_label_out <= '0;
      r_dist_out  <= '0;
`ifdef AM_MARGIN_EN
      r_margin_out <= '0;
`endif
      for (int ch = 0; ch < CHANNELS; ch++) begin
        r_best_dist[ch] <= '0;
        r_best_lbl[ch]  <= '0;
`ifdef AM_MARGIN_EN
        r_second_dist[ch] <= '0;
`endif
        for (int c = 0; c < CLASSES; c++) begin
          r_am[ch][c] <= '0;
        end
      end
    end else begin
      // Class-memory write; out-of-range targets match no entry and are ignored.
      if (w_wr_fire) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
          for (int c = 0; c < CLASSES; c++) begin
            if ((am_if.AmWrChannel_DI == CH_WIDTH'(ch)) &&
                (am_if.AmWrClass_DI == label_t'(c))) begin
              r_am[ch][c] <= am_if.AmWrData_DI;
            end
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          if (am_if.ValidIn_SI) begin
            r_query     <= w_majority;
            r_class_cnt <= '0;
            r_ready_out <= 1'b0;
            r_state     <= S_SEARCH;
          end
        end

        S_SEARCH: begin
          for (int ch = 0; ch < CHANNELS; ch++) begin
            r_best_dist[ch] <= w_nxt_best_dist[ch];
            r_best_lbl[ch]  <= w_nxt_best_lbl[ch];
`ifdef AM_MARGIN_EN
            r_second_dist[ch] <= w_nxt_second[ch];
`endif
          end
          if (w_last) begin
            // Latch the result including this cycle's compare.
            for (int ch = 0; ch < CHANNELS; ch++) begin
              r_label_out[ch*LABEL_WIDTH +: LABEL_WIDTH]      <= w_nxt_best_lbl[ch];
              r_dist_out[ch*DISTANCE_WIDTH +: DISTANCE_WIDTH] <= w_nxt_best_dist[ch];
`ifdef AM_MARGIN_EN
              r_margin_out[ch*DISTANCE_WIDTH +: DISTANCE_WIDTH] <= w_nxt_second[ch] - w_nxt_best_dist[ch];
`endif
            end
            r_class_cnt <= '0;
            r_valid_out <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_class_cnt <= r_class_cnt + label_t'(1);
          end
        end

        S_DONE: begin
          if (am_if.ReadyIn_SI) begin
            r_valid_out <= 1'b0;
            r_ready_out <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_valid_out <= 1'b0;
          r_ready_out <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign am_if.ReadyOut_SO    = r_ready_out;
  assign am_if.AmWrReady_SO   = r_ready_out;
  assign am_if.ValidOut_SO    = r_valid_out;
  assign am_if.LabelOut_DO    = r_label_out;
  assign am_if.DistanceOut_DO = r_dist_out;
`ifdef AM_MARGIN_EN
  assign am_if.MarginOut_DO   = r_margin_out;
`endif

endmodule

// File: tb/tb_associative_memory_multiclass.sv
// tb/tb_associative_memory_multiclass.sv - directed self-checking bench for associative_memory_multiclass
module tb_associative_memory_multiclass;
  localparam int HV = 16;
  localparam int CL = 4;
  localparam int CH = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   lat;

  associative_memory_multiclass_if #(.HV_DIMENSION(HV), .CLASSES(CL), .CHANNELS(CH)) am_bus ();

  associative_memory_multiclass #(.HV_DIMENSION(HV), .CLASSES(CL), .CHANNELS(CH)) dut (
    .Clk_CI   (clk),
    .Reset_RI (rst),
    .am_if    (am_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic am_write(input logic ch, input logic [1:0] cls, input logic [15:0] d);
    @(negedge clk);
    am_bus.AmWrEn_SI      = 1'b1;
    am_bus.AmWrChannel_DI = ch;
    am_bus.AmWrClass_DI   = cls;
    am_bus.AmWrData_DI    = d;
    @(negedge clk);
    am_bus.AmWrEn_SI      = 1'b0;
  endtask

  // Presents a query, returns cycles from acceptance edge to ValidOut_SO (bounded).
  task automatic run_query(input logic [15:0] m1, input logic [15:0] m2, input logic [15:0] m3,
                           output int l);
    @(negedge clk);
    am_bus.ValidIn_SI            = 1'b1;
    am_bus.HypervectorIn_mod1_DI = m1;
    am_bus.HypervectorIn_mod2_DI = m2;
    am_bus.HypervectorIn_mod3_DI = m3;
    @(posedge clk);
    #1;
    am_bus.ValidIn_SI = 1'b0;
    l = 0;
    while (!am_bus.ValidOut_SO && l < 20) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic ack;
    @(negedge clk);
    am_bus.ReadyIn_SI = 1'b1;
    @(negedge clk);
    am_bus.ReadyIn_SI = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    am_bus.ValidIn_SI            = 1'b0;
    am_bus.ReadyIn_SI            = 1'b0;
    am_bus.AmWrEn_SI             = 1'b0;
    am_bus.AmWrChannel_DI        = '0;
    am_bus.AmWrClass_DI          = '0;
    am_bus.AmWrData_DI           = '0;
    am_bus.HypervectorIn_mod1_DI = '0;
    am_bus.HypervectorIn_mod2_DI = '0;
    am_bus.HypervectorIn_mod3_DI = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_valid",   am_bus.ValidOut_SO, 0);
    check("rst_ready",   am_bus.ReadyOut_SO, 1);
    check("rst_wrready", am_bus.AmWrReady_SO, 1);
    check("rst_label",   am_bus.LabelOut_DO, 0);
    check("rst_dist",    am_bus.DistanceOut_DO, 0);

    // One-hot-block classes on ch0, their complements on ch1
    am_write(1'b0, 2'd0, 16'hF000);
    am_write(1'b0, 2'd1, 16'h0F00);
    am_write(1'b0, 2'd2, 16'h00F0);
    am_write(1'b0, 2'd3, 16'h000F);
    am_write(1'b1, 2'd0, 16'h0FFF);
    am_write(1'b1, 2'd1, 16'hF0FF);
    am_write(1'b1, 2'd2, 16'hFF0F);
    am_write(1'b1, 2'd3, 16'hFFF0);

    // Exact match on ch0 class 2; ch1 ties at 8 -> lowest index 0
    run_query(16'h00F0, 16'h00F0, 16'h00F0, lat);
    check("t1_latency", lat, 4);
    check("t1_label",   am_bus.LabelOut_DO, 2);           // {0,2}
    check("t1_dist",    am_bus.DistanceOut_DO, 256);      // {8,0}
`ifdef AM_MARGIN_EN
    check("t1_margin",  am_bus.MarginOut_DO, 8);          // {0,8}
`endif
    check("t1_ready_low", am_bus.ReadyOut_SO, 0);
    ack();
    check("t1_ready_back", am_bus.ReadyOut_SO, 1);
    check("t1_valid_drop", am_bus.ValidOut_SO, 0);

    // Majority: ones, ones, zeros -> all-ones query
    am_write(1'b0, 2'd0, 16'hFFFF);
    am_write(1'b1, 2'd0, 16'hFFFF);
    run_query(16'hFFFF, 16'hFFFF, 16'h0000, lat);
    check("t2_latency", lat, 4);
    check("t2_label",   am_bus.LabelOut_DO, 0);
    check("t2_dist",    am_bus.DistanceOut_DO, 0);
`ifdef AM_MARGIN_EN
    check("t2_margin",  am_bus.MarginOut_DO, 140);        // {4,12}
`endif
    ack();

    // Tie: ch0 classes 1 and 3 both at distance 5 from all-zeros
    am_write(1'b0, 2'd1, 16'h001F);
    am_write(1'b0, 2'd2, 16'h03FF);
    am_write(1'b0, 2'd3, 16'hF800);
    run_query(16'h0000, 16'h0000, 16'h0000, lat);
    check("t3_latency", lat, 4);
    check("t3_label",   am_bus.LabelOut_DO, 5);           // {1,1}
    check("t3_dist",    am_bus.DistanceOut_DO, 389);      // {12,5}
`ifdef AM_MARGIN_EN
    check("t3_margin",  am_bus.MarginOut_DO, 0);
`endif
    ack();

    // Back-pressure: hold DONE for 10 cycles, try a write that would change ch0
    run_query(16'h0000, 16'h0000, 16'h0000, lat);
    check("t4_latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        am_bus.AmWrEn_SI      = 1'b1;
        am_bus.AmWrChannel_DI = 1'b0;
        am_bus.AmWrClass_DI   = 2'd0;
        am_bus.AmWrData_DI    = 16'h0000;
      end else begin
        am_bus.AmWrEn_SI = 1'b0;
      end
      check("t4_hold_valid",   am_bus.ValidOut_SO, 1);
      check("t4_hold_ready",   am_bus.ReadyOut_SO, 0);
      check("t4_hold_wrready", am_bus.AmWrReady_SO, 0);
      check("t4_hold_label",   am_bus.LabelOut_DO, 5);
      check("t4_hold_dist",    am_bus.DistanceOut_DO, 389);
    end
    am_bus.AmWrEn_SI = 1'b0;
    ack();
    run_query(16'h0000, 16'h0000, 16'h0000, lat);
    check("t4_readback_label", am_bus.LabelOut_DO, 5);
    check("t4_readback_dist",  am_bus.DistanceOut_DO, 389);
    ack();

    // Async reset during SEARCH at c=1
    @(negedge clk);
    am_bus.ValidIn_SI            = 1'b1;
    am_bus.HypervectorIn_mod1_DI = 16'h0123;
    am_bus.HypervectorIn_mod2_DI = 16'h0123;
    am_bus.HypervectorIn_mod3_DI = 16'h0123;
    @(posedge clk);
    #1;
    am_bus.ValidIn_SI = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", am_bus.ValidOut_SO, 0);
    check("t5_rst_ready", am_bus.ReadyOut_SO, 1);
    check("t5_rst_label", am_bus.LabelOut_DO, 0);
    check("t5_rst_dist",  am_bus.DistanceOut_DO, 0);
    @(negedge clk);
    rst = 1'b0;
    run_query(16'h0123, 16'h0123, 16'h0123, lat);
    check("t5_latency", lat, 4);
    check("t5_label",   am_bus.LabelOut_DO, 0);
    check("t5_dist",    am_bus.DistanceOut_DO, 132);      // {4,4}
`ifdef AM_MARGIN_EN
    check("t5_margin",  am_bus.MarginOut_DO, 0);
`endif
    ack();

    // Simultaneous write to AM[1][0] and query acceptance
    @(negedge clk);
    am_bus.AmWrEn_SI             = 1'b1;
    am_bus.AmWrChannel_DI        = 1'b1;
    am_bus.AmWrClass_DI          = 2'd0;
    am_bus.AmWrData_DI           = 16'h0123;
    am_bus.ValidIn_SI            = 1'b1;
    am_bus.HypervectorIn_mod1_DI = 16'h0123;
    am_bus.HypervectorIn_mod2_DI = 16'h0123;
    am_bus.HypervectorIn_mod3_DI = 16'h0123;
    check("t6_wrready", am_bus.AmWrReady_SO, 1);
    @(posedge clk);
    #1;
    am_bus.AmWrEn_SI  = 1'b0;
    am_bus.ValidIn_SI = 1'b0;
    lat = 0;
    while (!am_bus.ValidOut_SO && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("t6_latency", lat, 4);
    check("t6_label",   am_bus.LabelOut_DO, 0);
    check("t6_dist",    am_bus.DistanceOut_DO, 4);        // {0,4}
`ifdef AM_MARGIN_EN
    check("t6_margin",  am_bus.MarginOut_DO, 128);        // {4,0}
`endif
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
